// File: rtl/pipelined_segmented_addsub.sv
// Unsigned WIDTH-bit add/subtract whose carry chain is split across STAGES
// registered segments, with valid/ready flow control on both ports.
module pipelined_segmented_addsub #(
    parameter int WIDTH  = 24,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [TAG_W-1:0] out_tag
);
    localparam int SEG  = (WIDTH + STAGES - 1) / STAGES;
    localparam int LAST = STAGES - 1;

    function automatic logic [WIDTH-1:0] seg_mask(input int lo, input int hi);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= lo && i < hi) m[i] = 1'b1;
        end
        return m;
    endfunction

    logic [STAGES-1:0] stage_load;
    logic              stage_valid [STAGES];
    logic              stage_carry [STAGES];
    logic              stage_sub   [STAGES];
    logic [WIDTH-1:0]  stage_a     [STAGES];
    logic [WIDTH-1:0]  stage_b     [STAGES];
    logic [WIDTH-1:0]  stage_s     [STAGES];
    logic [TAG_W-1:0]  stage_tag   [STAGES];

    // Handshake: a word moves across a boundary on an edge where the sender
    // holds valid and the receiver shows ready. A stage loads when empty or
    // when its own word leaves on the same edge, so ready ripples upstream
    // combinationally from out_ready and bubbles are squeezed out.
    always_comb begin : p_load
        logic take;
        take       = out_ready;
        stage_load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stage_load[k] = !stage_valid[k] || take;
            take          = stage_load[k];
        end
    end

    assign in_ready = stage_load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int HI = (LO + SEG > WIDTH) ? WIDTH : LO + SEG;

        logic             src_valid;
        logic             src_carry;
        logic             src_sub;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic [TAG_W-1:0] src_tag;
        logic [WIDTH-1:0] next_s;
        logic             next_carry;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + 1: invert B once and seed the carry.
            assign src_valid = in_valid;
            assign src_carry = in_sub;
            assign src_sub   = in_sub;
            assign src_a     = in_a;
            assign src_b     = in_sub ? ~in_b : in_b;
            assign src_s     = '0;
            assign src_tag   = in_tag;
        end else begin : g_tail
            assign src_valid = stage_valid[k-1];
            assign src_carry = stage_carry[k-1];
            assign src_sub   = stage_sub[k-1];
            assign src_a     = stage_a[k-1];
            assign src_b     = stage_b[k-1];
            assign src_s     = stage_s[k-1];
            assign src_tag   = stage_tag[k-1];
        end

        if (LO < WIDTH) begin : g_seg
            localparam logic [WIDTH-1:0] MASK = seg_mask(LO, HI);
            logic [WIDTH:0] seg_sum;

            assign seg_sum    = {1'b0, src_a & MASK} + {1'b0, src_b & MASK}
                              + ({{WIDTH{1'b0}}, src_carry} << LO);
            assign next_s     = src_s | (seg_sum[WIDTH-1:0] & MASK);
            assign next_carry = |(seg_sum >> HI);
        end else begin : g_pass
            assign next_s     = src_s;
            assign next_carry = src_carry;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stage_valid[k] <= 1'b0;
                stage_carry[k] <= 1'b0;
                stage_sub[k]   <= 1'b0;
                stage_a[k]     <= '0;
                stage_b[k]     <= '0;
                stage_s[k]     <= '0;
                stage_tag[k]   <= '0;
            end else if (stage_load[k]) begin
                stage_valid[k] <= src_valid;
                if (src_valid) begin
                    stage_carry[k] <= next_carry;
                    stage_sub[k]   <= src_sub;
                    stage_a[k]     <= src_a;
                    stage_b[k]     <= src_b;
                    stage_s[k]     <= next_s;
                    stage_tag[k]   <= src_tag;
                end
            end
        end
    end

    // For subtraction the top bit reports a borrow, the inverse of the carry.
    assign out_valid = stage_valid[LAST];
    assign out_sum   = {stage_carry[LAST] ^ stage_sub[LAST], stage_s[LAST]};
    assign out_tag   = stage_tag[LAST];

endmodule

// File: tb/tb_pipelined_segmented_addsub.sv
// Bench for pipelined_segmented_addsub: directed timing cases on a 3-stage
// instance plus random traffic on 3-, 1- and 24-stage instances.
module tb_pipelined_segmented_addsub;
  localparam int W  = 24;
  localparam int TW = 4;
  localparam int EW = TW + W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sub;
  logic          out_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;

  logic          in_ready_x  [3];
  logic          out_valid_x [3];
  logic [W:0]    out_sum_x   [3];
  logic [TW-1:0] out_tag_x   [3];

  int n_checks;
  int n_fail;
  int pend [3];

  always #5 clk = ~clk;

  pipelined_segmented_addsub #(.WIDTH(W), .STAGES(3), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_x[0]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid_x[0]), .out_ready(out_ready),
    .out_sum(out_sum_x[0]), .out_tag(out_tag_x[0]));

  pipelined_segmented_addsub #(.WIDTH(W), .STAGES(1), .TAG_W(TW)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_x[1]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid_x[1]), .out_ready(out_ready),
    .out_sum(out_sum_x[1]), .out_tag(out_tag_x[1]));

  pipelined_segmented_addsub #(.WIDTH(W), .STAGES(W), .TAG_W(TW)) dut_s24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_x[2]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid_x[2]), .out_ready(out_ready),
    .out_sum(out_sum_x[2]), .out_tag(out_tag_x[2]));

  // Golden result: plain unsigned arithmetic one bit wider than the operands.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic [TW-1:0] tag);
    logic [W:0] r;
    if (sub) r = {1'b0, a} - {1'b0, b};
    else     r = {1'b0, a} + {1'b0, b};
    return {tag, r};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {W{1'b1}};
      2:       return 24'h800000;
      3:       return 24'h7FFFFF;
      default: return r[W-1:0];
    endcase
  endfunction

  // Scoreboards: one expected queue per instance, plus output-hold checking.
  for (genvar d = 0; d < 3; d++) begin : g_sb
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_item;
    logic          held;
    logic [W:0]    held_sum;
    logic [TW-1:0] held_tag;

    initial held = 1'b0;

    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        held = 1'b0;
      end else begin
        if (held) begin
          n_checks++;
          if (out_valid_x[d] !== 1'b1 || out_sum_x[d] !== held_sum || out_tag_x[d] !== held_tag) begin
            n_fail++;
            $display("FAIL hold dut%0d: got v=%b sum=%h tag=%h, required v=1 sum=%h tag=%h",
                     d, out_valid_x[d], out_sum_x[d], out_tag_x[d], held_sum, held_tag);
          end
        end
        if (in_valid && in_ready_x[d]) exp_q.push_back(model(in_a, in_b, in_sub, in_tag));
        if (out_valid_x[d] && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra dut%0d: got tag=%h sum=%h, required no result",
                     d, out_tag_x[d], out_sum_x[d]);
          end else begin
            exp_item = exp_q.pop_front();
            if ({out_tag_x[d], out_sum_x[d]} !== exp_item) begin
              n_fail++;
              $display("FAIL sb_result dut%0d: got tag=%h sum=%h, required tag=%h sum=%h",
                       d, out_tag_x[d], out_sum_x[d], exp_item[EW-1:W+1], exp_item[W:0]);
            end
          end
        end
        held     = out_valid_x[d] && !out_ready;
        held_sum = out_sum_x[d];
        held_tag = out_tag_x[d];
      end
      pend[d] = exp_q.size();
    end
  end

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_tag   = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks += 4;
      if (out_valid_x[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid dut%0d: got %b, required 0", d, out_valid_x[d]); end
      if (out_sum_x[d] !== '0) begin n_fail++; $display("FAIL reset_sum dut%0d: got %h, required 0", d, out_sum_x[d]); end
      if (out_tag_x[d] !== '0) begin n_fail++; $display("FAIL reset_tag dut%0d: got %h, required 0", d, out_tag_x[d]); end
      if (in_ready_x[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b, required 1", d, in_ready_x[d]); end
    end
  endtask

  // One operation into the 3-stage instance; checks latency and result.
  task automatic run_single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic [TW-1:0] tag, input logic [W:0] exp_sum);
    int lat;
    bit seen;
    @(posedge clk);
    #1 drive_op(a, b, sub, tag);
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready_x[0] !== 1'b1) begin n_fail++; $display("FAIL %s_accept: got in_ready=%b, required 1", name, in_ready_x[0]); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0;
    lat  = 0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      @(negedge clk);
      if (out_valid_x[0]) begin seen = 1; lat = c; end
      else @(posedge clk);
    end
    n_checks += 3;
    if (!seen || lat != 3) begin n_fail++; $display("FAIL %s_latency: got %0d cycles (seen=%0d), required 3", name, lat, seen); end
    if (out_sum_x[0] !== exp_sum) begin n_fail++; $display("FAIL %s_sum: got %h, required %h", name, out_sum_x[0], exp_sum); end
    if (out_tag_x[0] !== tag) begin n_fail++; $display("FAIL %s_tag: got %h, required %h", name, out_tag_x[0], tag); end
  endtask

  task automatic test_carry();
    run_single("carry", 24'hFFFFFF, 24'h000001, 1'b0, 4'd5, 25'h1000000);
  endtask

  task automatic test_sub();
    run_single("sub_borrow", 24'h000005, 24'h000007, 1'b1, 4'd9, 25'h1FFFFFE);
    run_single("sub_wrap", 24'h800000, 24'h000001, 1'b1, 4'd3, 25'h07FFFFF);
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (c < 8) drive_op(pick(), pick(), 1'($urandom_range(0, 1)), 4'(c));
      else in_valid = 1'b0;
      @(negedge clk);
      if (c < 8) begin
        n_checks++;
        if (in_ready_x[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready c=%0d: got %b, required 1", c, in_ready_x[0]); end
      end
      if (out_valid_x[0]) begin
        n_checks++;
        if (out_tag_x[0] !== 4'(seen) || c != seen + 3) begin
          n_fail++;
          $display("FAIL b2b_order: got tag=%h at cycle %0d, required tag=%h at cycle %0d", out_tag_x[0], c, 4'(seen), seen + 3);
        end
        seen++;
      end
    end
    n_checks++;
    if (seen != 8) begin n_fail++; $display("FAIL b2b_count: got %0d results, required 8", seen); end
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      out_ready = (c >= 6);
      if (c < 16) drive_op(pick(), pick(), 1'($urandom_range(0, 1)), 4'(acc));
      else in_valid = 1'b0;
      @(negedge clk);
      if (c < 6) begin
        n_checks++;
        if (in_ready_x[0] !== (c < 3)) begin n_fail++; $display("FAIL bp_ready c=%0d: got %b, required %b", c, in_ready_x[0], (c < 3)); end
      end else if (c < 16) begin
        n_checks++;
        if (out_valid_x[0] !== 1'b1) begin n_fail++; $display("FAIL bp_stream c=%0d: got out_valid=%b, required 1", c, out_valid_x[0]); end
      end
      if (in_valid && in_ready_x[0]) acc++;
    end
    n_checks++;
    if (acc != 13) begin n_fail++; $display("FAIL bp_accepts: got %0d, required 13", acc); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1 drive_op(24'h123456, 24'h000111, 1'b0, 4'hA);
    @(posedge clk);
    #1 drive_op(24'h000010, 24'h000020, 1'b1, 4'hB);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (out_valid_x[0] !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b, required 0", out_valid_x[0]); end
    if (in_ready_x[0] !== 1'b1) begin n_fail++; $display("FAIL mr_ready: got %b, required 1", in_ready_x[0]); end
    if (out_sum_x[0] !== '0) begin n_fail++; $display("FAIL mr_sum: got %h, required 0", out_sum_x[0]); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid_x[0] !== 1'b0) begin n_fail++; $display("FAIL mr_ghost c=%0d: got out_valid=1 tag=%h, required 0", c, out_tag_x[0]); end
    end
  endtask

  task automatic test_random();
    int acc [3];
    int cyc;
    for (int d = 0; d < 3; d++) acc[d] = 0;
    cyc = 0;
    while ((acc[0] < 1000 || acc[1] < 1000 || acc[2] < 1000) && cyc < 10000) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        drive_op(pick(), pick(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      else
        in_valid = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (in_valid && in_ready_x[d]) acc[d]++;
      cyc++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && (pend[0] != 0 || pend[1] != 0 || pend[2] != 0); c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (pend[d] != 0 || acc[d] < 1000) begin
        n_fail++;
        $display("FAIL rand_drain dut%0d: got %0d pending after %0d accepts, required 0 pending after >=1000", d, pend[d], acc[d]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    n_checks  = 0;
    n_fail    = 0;
    test_reset();
    test_carry();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
